// File: rtl/score_keeper.sv
// Scoring stage: turns monster kill pulses into a packed-BCD running score
// and session high score, adding one BCD digit per cycle.
module score_keeper #(
  parameter int unsigned MONSTERS = 12,
  parameter int unsigned PEND_W   = 8
) (
  input  logic                clk,
  input  logic                power,
  input  logic                alive,
  input  logic [MONSTERS-1:0] score_pulse,
  input  logic                show_high,
  output logic [15:0]         score,
  output logic [15:0]         high_score,
  output logic [15:0]         display,
  output logic                busy,
  output logic                saturated
);

  localparam int unsigned CNT_W   = $clog2(MONSTERS + 1);
  localparam int unsigned EXT_W   = PEND_W + CNT_W;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 16;
  localparam logic [PEND_W-1:0] PEND_MAX   = '1;
  localparam logic [PEND_W-1:0] CHUNK_MAX  = PEND_W'(9);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  state_t              r_state;
  logic [MONSTERS-1:0] r_prev_pulse;
  logic                r_prev_alive;
  logic [PEND_W-1:0]   r_pending;
  logic [DIGIT_W-1:0]  r_addend;
  logic [BCD_W-1:0]    r_work;
  logic [1:0]          r_idx;
  logic                r_carry;
  logic [BCD_W-1:0]    r_score;
  logic [BCD_W-1:0]    r_high;
  logic                r_sat;
  logic                r_busy;

  logic [MONSTERS-1:0] w_new;
  logic [CNT_W-1:0]    w_pop;
  logic [CNT_W-1:0]    w_count;
  logic                w_start;
  logic                w_new_game;
  logic [PEND_W-1:0]   w_taken;
  logic [EXT_W-1:0]    w_pend_sum;
  logic [PEND_W-1:0]   w_pend_next;
  logic [DIGIT_W-1:0]  w_digit;
  logic [4:0]          w_sum;
  logic                w_carry;
  logic [DIGIT_W-1:0]  w_digit_new;
  logic [BCD_W-1:0]    w_work_next;

  // Rising-edge kill detection and saturating pending-kill bookkeeping
  always_comb begin
    w_new      = score_pulse & ~r_prev_pulse;
    w_new_game = alive & ~r_prev_alive;
    w_pop      = '0;
    for (int i = 0; i < int'(MONSTERS); i++) begin
      w_pop = w_pop + CNT_W'(w_new[i]);
    end
    w_count     = (alive && !r_sat) ? w_pop : '0;
    w_start     = (r_state == S_IDLE) && (r_pending != '0) && !r_sat;
    w_taken     = !w_start ? '0 : ((r_pending > CHUNK_MAX) ? CHUNK_MAX : r_pending);
    w_pend_sum  = EXT_W'(r_pending) - EXT_W'(w_taken) + EXT_W'(w_count);
    w_pend_next = (w_pend_sum > EXT_W'(PEND_MAX)) ? PEND_MAX : PEND_W'(w_pend_sum);
  end

  // One BCD digit of the running add; the addend only enters at digit 0
  always_comb begin
    w_digit     = r_work[{r_idx, 2'b00} +: DIGIT_W];
    w_sum       = 5'(w_digit) + ((r_idx == 2'd0) ? 5'(r_addend) : 5'd0) + 5'(r_carry);
    w_carry     = (w_sum > 5'd9);
    w_digit_new = w_carry ? 4'(w_sum - 5'd10) : 4'(w_sum);
    w_work_next = r_work;
    w_work_next[{r_idx, 2'b00} +: DIGIT_W] = w_digit_new;
  end

  always_ff @(posedge clk) begin
    if (power) begin
      r_state      <= S_IDLE;
      r_prev_pulse <= '0;
      r_prev_alive <= 1'b0;
      r_pending    <= '0;
      r_addend     <= '0;
      r_work       <= '0;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_score      <= '0;
      r_high       <= '0;
      r_sat        <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_prev_pulse <= score_pulse;
      r_prev_alive <= alive;
      if (w_new_game) begin
        // New game aborts any in-flight add so score never shows a partial value
        r_score   <= '0;
        r_sat     <= 1'b0;
        r_pending <= '0;
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_carry   <= 1'b0;
        r_idx     <= '0;
      end else begin
        r_pending <= r_sat ? '0 : w_pend_next;
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_addend <= DIGIT_W'(w_taken);
              r_work   <= r_score;
              r_carry  <= 1'b0;
              r_idx    <= '0;
              r_state  <= S_ADD;
              r_busy   <= 1'b1;
            end
          end
          S_ADD: begin
            r_work  <= w_work_next;
            r_carry <= w_carry;
            r_idx   <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= S_HIGH;
              if (w_carry) begin
                r_score   <= 16'h9999;
                r_sat     <= 1'b1;
                r_pending <= '0;
              end else begin
                r_score <= w_work_next;
              end
            end
          end
          S_HIGH: begin
            if (r_score > r_high) begin
              r_high <= r_score;
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign score      = r_score;
  assign high_score = r_high;
  assign display    = show_high ? r_high : r_score;
  assign busy       = r_busy;
  assign saturated  = r_sat;

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected scores are queued as kills are
// driven and popped whenever the DUT score changes.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        power;
  logic        alive;
  logic [11:0] score_pulse;
  logic        show_high;
  logic [15:0] score;
  logic [15:0] high_score;
  logic [15:0] display;
  logic        busy;
  logic        saturated;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] q_exp[$];

  score_keeper #(.MONSTERS(12), .PEND_W(8)) dut (
    .clk        (clk),
    .power      (power),
    .alive      (alive),
    .score_pulse(score_pulse),
    .show_high  (show_high),
    .score      (score),
    .high_score (high_score),
    .display    (display),
    .busy       (busy),
    .saturated  (saturated)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    int idle;
    idle = 0;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) idle = 0;
      else idle++;
      if (idle >= 3) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_power;
    power = 1'b1;
    alive = 1'b0;
    score_pulse = '0;
    tick();
    tick();
    power = 1'b0;
  endtask

  task automatic new_game;
    alive = 1'b0;
    tick();
    alive = 1'b1;
    tick();
  endtask

  // Feeds n kills as single-cycle bursts of at most nine, letting each drain
  task automatic add_kills(input int n);
    int k;
    bit to;
    while (n > 0) begin
      k = (n > 9) ? 9 : n;
      score_pulse = 12'((1 << k) - 1);
      tick();
      score_pulse = '0;
      tick();
      wait_done(60, to);
      n_checks++;
      if (to) begin
        n_errors++;
        $display("FAIL add_kills_timeout: busy did not settle, remaining=%0d", n);
        return;
      end
      n = n - k;
    end
  endtask

  task automatic test_reset;
    show_high = 1'b0;
    do_power();
    n_checks++;
    if (score !== 16'h0 || high_score !== 16'h0 || display !== 16'h0 ||
        busy !== 1'b0 || saturated !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: score=%h high=%h disp=%h busy=%b sat=%b, want all 0",
               score, high_score, display, busy, saturated);
    end
  endtask

  task automatic test_single;
    logic [15:0] last, exp;
    alive = 1'b1;
    tick();
    score_pulse = 12'h001;
    tick();
    q_exp.push_back(16'h0001);
    last = score;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 2) score_pulse = '0;
      if (k <= 5) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_errors++;
          $display("FAIL single_busy: E+%0d busy=%b, want 1", k, busy);
        end
      end
      if (score !== last) begin
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
        n_checks++;
        if (score !== exp || k != 5) begin
          n_errors++;
          $display("FAIL single_score: E+%0d score=%h, want %h at E+5", k, score, exp);
        end
        last = score;
      end
      n_checks++;
      if (high_score !== ((k >= 6) ? 16'h0001 : 16'h0000)) begin
        n_errors++;
        $display("FAIL single_high: E+%0d high=%h", k, high_score);
      end
    end
    for (int k = 0; k < 6; k++) tick();
    n_checks++;
    if (score !== 16'h0001 || busy !== 1'b0 || q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL single_once: score=%h busy=%b left=%0d, want 0001 0 0",
               score, busy, q_exp.size());
    end
  endtask

  task automatic test_carry;
    logic [15:0] last, exp;
    int changes, busy_cycles;
    new_game();
    add_kills(98);
    n_checks++;
    if (score !== 16'h0098) begin
      n_errors++;
      $display("FAIL carry_preset: score=%h, want 0098", score);
    end
    q_exp.push_back(16'h0101);
    score_pulse = 12'h821;
    tick();
    score_pulse = '0;
    last = score;
    changes = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy) busy_cycles++;
      if (score !== last) begin
        changes++;
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
        n_checks++;
        if (score !== exp) begin
          n_errors++;
          $display("FAIL carry_score: score=%h, want %h", score, exp);
        end
        last = score;
      end
    end
    n_checks++;
    if (changes != 1 || busy_cycles < 5 || busy_cycles > 6 || high_score !== 16'h0101) begin
      n_errors++;
      $display("FAIL carry_txn: changes=%0d busy_cycles=%0d high=%h, want 1 5..6 0101",
               changes, busy_cycles, high_score);
    end
  endtask

  task automatic test_burst;
    logic [15:0] last, exp;
    new_game();
    q_exp.push_back(16'h0009);
    q_exp.push_back(16'h0012);
    score_pulse = 12'hFFF;
    tick();
    score_pulse = '0;
    last = score;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (score !== last) begin
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
        n_checks++;
        if (score !== exp) begin
          n_errors++;
          $display("FAIL burst_score: score=%h, want %h", score, exp);
        end
        last = score;
      end
    end
    n_checks++;
    if (q_exp.size() != 0 || score !== 16'h0012 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL burst_end: left=%0d score=%h busy=%b, want 0 0012 0",
               q_exp.size(), score, busy);
      q_exp.delete();
    end
  endtask

  task automatic test_new_game;
    bit saw_busy;
    do_power();
    alive = 1'b1;
    tick();
    add_kills(42);
    n_checks++;
    if (score !== 16'h0042 || high_score !== 16'h0042) begin
      n_errors++;
      $display("FAIL ng_preset: score=%h high=%h, want 0042 0042", score, high_score);
    end
    alive = 1'b0;
    tick();
    alive = 1'b1;
    score_pulse = 12'h008;
    tick();
    n_checks++;
    if (score !== 16'h0000 || high_score !== 16'h0042 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL ng_edge: score=%h high=%h busy=%b, want 0000 0042 0",
               score, high_score, busy);
    end
    saw_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    score_pulse = '0;
    n_checks++;
    if (score !== 16'h0000 || saw_busy) begin
      n_errors++;
      $display("FAIL ng_dropped: score=%h saw_busy=%b, want 0000 0", score, saw_busy);
    end
    show_high = 1'b1;
    #1;
    n_checks++;
    if (display !== 16'h0042) begin
      n_errors++;
      $display("FAIL ng_disp_high: display=%h, want 0042", display);
    end
    show_high = 1'b0;
    #1;
    n_checks++;
    if (display !== 16'h0000) begin
      n_errors++;
      $display("FAIL ng_disp_score: display=%h, want 0000", display);
    end
  endtask

  task automatic test_mid_reset;
    score_pulse = 12'h001;
    tick();
    score_pulse = '0;
    tick();
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_busy: busy=%b before abort, want 1", busy);
    end
    power = 1'b1;
    tick();
    n_checks++;
    if (score !== 16'h0 || high_score !== 16'h0 || display !== 16'h0 ||
        busy !== 1'b0 || saturated !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_out: score=%h high=%h disp=%h busy=%b sat=%b, want all 0",
               score, high_score, display, busy, saturated);
    end
    power = 1'b0;
    tick();
  endtask

  task automatic test_saturate;
    logic [15:0] last, exp;
    bit saw_busy;
    add_kills(9997);
    n_checks++;
    if (score !== 16'h9997 || saturated !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_preset: score=%h sat=%b, want 9997 0", score, saturated);
    end
    q_exp.push_back(16'h9999);
    score_pulse = 12'h01F;
    tick();
    score_pulse = '0;
    last = score;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (score !== last) begin
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 16'hxxxx;
        n_checks++;
        if (score !== exp) begin
          n_errors++;
          $display("FAIL sat_score: score=%h, want %h", score, exp);
        end
        last = score;
      end
    end
    n_checks++;
    if (saturated !== 1'b1 || high_score !== 16'h9999 || q_exp.size() != 0) begin
      n_errors++;
      $display("FAIL sat_flag: sat=%b high=%h left=%0d, want 1 9999 0",
               saturated, high_score, q_exp.size());
    end
    score_pulse = 12'hFFF;
    tick();
    score_pulse = '0;
    saw_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy) saw_busy = 1'b1;
    end
    n_checks++;
    if (score !== 16'h9999 || saw_busy) begin
      n_errors++;
      $display("FAIL sat_hold: score=%h saw_busy=%b, want 9999 0", score, saw_busy);
    end
  endtask

  initial begin
    power = 1'b1;
    alive = 1'b0;
    score_pulse = '0;
    show_high = 1'b0;
    test_reset();
    test_single();
    test_carry();
    test_burst();
    test_new_game();
    test_mid_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
